// File: rtl/coproc_pkg.sv
// coproc_pkg: op codes, output selects, shift formats and FSM states for coproc_mdu
package coproc_pkg;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_SHF = 4'hB;
  localparam logic [3:0] SEL_BUSY = 4'd0;
  localparam logic [3:0] SEL_OPT = 4'd1;
  localparam logic [3:0] SEL_HI = 4'd2;
  localparam logic [3:0] SEL_LO = 4'd3;
  localparam logic [3:0] SEL_QUOT = 4'd4;
  localparam logic [3:0] SEL_REM = 4'd5;
  localparam logic [3:0] SEL_SHI = 4'd6;
  localparam logic [3:0] SEL_SLO = 4'd7;
  localparam logic [1:0] FMT_SLL = 2'b00;
  localparam logic [1:0] FMT_SRL = 2'b01;
  localparam logic [1:0] FMT_SRA = 2'b10;
  localparam logic [1:0] FMT_ROL = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
endpackage

// File: rtl/mdu_core.sv
// mdu_core: shared 2*WIDTH shift register, WIDTH+1 add/sub and step counter.
// The shift datapath and fmt port exist only when COPROC_MDU_SHIFT_EN is defined.
module mdu_core import coproc_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CNTW = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               neg,
  input  logic [3:0]         op,
`ifdef COPROC_MDU_SHIFT_EN
  input  logic [1:0]         fmt,
`endif
  input  logic [2*WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0]   m_in,
  input  logic [CNTW-1:0]    k_in,
  output logic [2*WIDTH-1:0] res,
  output logic               last
);
  logic [2*WIDTH-1:0] p, mul_nxt, div_nxt, fix_val;
  logic [WIDTH-1:0]   m;
  logic [CNTW-1:0]    k;
  logic [WIDTH:0]     acc, add, sum;
  logic               div;
  assign div = op == OP_DIV;
  // Divide subtracts the divisor from {rem,next dividend bit}; multiply adds the multiplicand when lsb is set.
  assign acc = div ? p[2*WIDTH-1:WIDTH-1] : {1'b0, p[2*WIDTH-1:WIDTH]};
  assign add = div ? ~{1'b0, m} : (p[0] ? {1'b0, m} : '0);
  assign sum = acc + add + {{WIDTH{1'b0}}, div};
  assign mul_nxt = {sum, p[WIDTH-1:1]};
  assign div_nxt = sum[WIDTH] ? {p[2*WIDTH-2:0], 1'b0} : {sum[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  assign fix_val = neg ? -p : p;
  assign last = k == CNTW'(1);
`ifdef COPROC_MDU_SHIFT_EN
  logic [2*WIDTH-1:0] shf_nxt;
  assign shf_nxt = fmt == FMT_SLL ? {p[2*WIDTH-2:0], 1'b0}
                 : fmt == FMT_SRL ? {1'b0, p[2*WIDTH-1:1]}
                 : fmt == FMT_SRA ? {p[2*WIDTH-1], p[2*WIDTH-1:1]}
                 : {p[2*WIDTH-2:0], p[2*WIDTH-1]};
  assign res = fix ? fix_val : div ? div_nxt : op == OP_SHF ? shf_nxt : mul_nxt;
`else
  assign res = fix ? fix_val : div ? div_nxt : mul_nxt;
`endif
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      p <= '0;
      m <= '0;
      k <= '0;
    end else if (load) begin
      p <= p_in;
      m <= m_in;
      k <= k_in;
    end else if (step || fix) begin
      p <= res;
      k <= k - CNTW'(1);
    end
endmodule

// File: rtl/coproc_mdu.sv
// coproc_mdu: iterative multiply/divide/shift coprocessor with held results and sticky output select.
// Define COPROC_MDU_SHIFT_EN to include the shift op and output selects 6/7.
module coproc_mdu import coproc_pkg::*; #(
  parameter int         WIDTH   = 16,
  parameter logic [7:0] OPTIONS = 8'h07
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             go,
  input  logic [10:0]      sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic             busy
);
  localparam int CNTW = $clog2(2*WIDTH);
`ifdef COPROC_MDU_SHIFT_EN
  localparam logic [7:0] OPTS = OPTIONS | 8'h04;
`else
  localparam logic [7:0] OPTS = OPTIONS & 8'hfb;
`endif
  state_e state, state_nxt;
  logic [3:0]         op, op_r, sticky, outsel;
  logic               neg, ovf, start, mul_go, div_go, div_ovf, shf_go;
  logic               load, step, fix, done, last, unused_mode;
  logic [WIDTH-1:0]   ma, mb, hi, lo, quot, rem, y_nxt;
  logic [CNTW-1:0]    k_in;
  logic [2*WIDTH-1:0] res;
  assign op = sel[4:1];
  assign start = go && state == IDLE;
  assign mul_go = start && op == OP_MUL;
  assign div_go = start && op == OP_DIV;
  assign div_ovf = div_go && a >= c;
  assign ma = sel[10] && a[WIDTH-1] ? -a : a;
  assign mb = sel[10] && b[WIDTH-1] ? -b : b;
  assign unused_mode = &{1'b0, sel[9:5]};
`ifdef COPROC_MDU_SHIFT_EN
  logic [WIDTH-1:0] shi, slo;
  logic [1:0]       fmt_r;
  assign shf_go = start && op == OP_SHF;
  assign k_in = shf_go ? c[CNTW-1:0] : CNTW'(WIDTH);
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      fmt_r <= '0;
      shi <= '0;
      slo <= '0;
    end else begin
      if (load) fmt_r <= sel[6:5];
      if (shf_go && k_in == '0) {shi, slo} <= {a, b};
      else if (done && op_r == OP_SHF) {shi, slo} <= res;
    end
`else
  assign shf_go = 1'b0;
  assign k_in = CNTW'(WIDTH);
`endif
  always_comb begin
    load = mul_go || (div_go && !div_ovf) || (shf_go && k_in != '0);
    step = state == RUN;
    fix = state == FIX;
    busy = state != IDLE;
    done = fix || (step && last && op_r != OP_MUL);
    state_nxt = load ? RUN : step && last ? (op_r == OP_MUL ? FIX : IDLE) : fix ? IDLE : state;
  end
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      op_r <= '0;
      neg <= 1'b0;
      ovf <= 1'b0;
      hi <= '0;
      lo <= '0;
      quot <= '0;
      rem <= '0;
      sticky <= '0;
      y <= '0;
    end else begin
      if (load) begin
        op_r <= op;
        neg <= sel[10] && (a[WIDTH-1] ^ b[WIDTH-1]);
      end
      if (done && op_r == OP_MUL) {hi, lo} <= res;
      if (div_ovf) begin
        ovf <= 1'b1;
        quot <= '1;
        rem <= '1;
      end else if (done && op_r == OP_DIV) begin
        ovf <= 1'b0;
        {rem, quot} <= res;
      end
      if (go) sticky <= sel[3:0];
      y <= y_nxt;
    end
  always_comb begin
    outsel = go ? sel[3:0] : sticky;
    y_nxt = outsel == SEL_BUSY ? WIDTH'(busy)
          : outsel == SEL_OPT ? WIDTH'({ovf, OPTS})
          : outsel == SEL_HI ? hi
          : outsel == SEL_LO ? lo
          : outsel == SEL_QUOT ? quot
          : outsel == SEL_REM ? rem
`ifdef COPROC_MDU_SHIFT_EN
          : outsel == SEL_SHI ? shi
          : outsel == SEL_SLO ? slo
`endif
          : '0;
  end
  mdu_core #(.WIDTH(WIDTH), .CNTW(CNTW)) core (
    .clk(clk),
    .arstn(arstn),
    .load(load),
    .step(step),
    .fix(fix),
    .neg(neg),
    .op(op_r),
`ifdef COPROC_MDU_SHIFT_EN
    .fmt(fmt_r),
`endif
    .p_in(mul_go ? {{WIDTH{1'b0}}, mb} : {a, b}),
    .m_in(mul_go ? ma : c),
    .k_in(k_in),
    .res(res),
    .last(last)
  );
endmodule

// File: tb/tb_coproc_mdu.sv
// tb_coproc_mdu: directed vectors with hand-computed results for coproc_mdu at WIDTH=16
module tb_coproc_mdu;
  localparam int W = 16;
`ifdef COPROC_MDU_SHIFT_EN
  localparam logic [W-1:0] OPT = 16'h0007;
`else
  localparam logic [W-1:0] OPT = 16'h0003;
`endif
  logic clk = 1'b0, arstn = 1'b0, go = 1'b0, busy;
  logic [10:0] sel = '0;
  logic [W-1:0] a = '0, b = '0, c = '0, y;
  int vectors = 0, miscompares = 0;
  coproc_mdu #(.WIDTH(W), .OPTIONS(8'h07)) dut (
    .clk(clk), .arstn(arstn), .go(go), .sel(sel), .a(a), .b(b), .c(c), .y(y), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [10:0] cmd(input logic sg, input logic [1:0] fmt, input logic [3:0] op);
    return {sg, 3'b000, fmt, op, 1'b0};
  endfunction
  task automatic issue(input logic [10:0] s, input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic);
    go = 1'b1;
    sel = s;
    a = ia;
    b = ib;
    c = ic;
    tick();
    go = 1'b0;
  endtask
  task automatic read(input string tag, input logic [3:0] os, input logic [W-1:0] exp);
    issue({7'b0, os}, a, b, c);
    check(tag, y, exp);
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask
  initial begin
    int n;
    repeat (2) tick();
    check("rst_y", y, '0);
    check("rst_busy", W'(busy), '0);
    arstn = 1'b1;
    tick();
    read("rst_hi", 4'd2, '0);
    read("rst_opt", 4'd1, OPT);
    issue(cmd(1'b0, 2'b00, 4'h9), 16'hFFFF, 16'hFFFF, '0);
    wait_idle(n);
    check("mulu_busy", W'(n), 16'd17);
    read("mulu_hi", 4'd2, 16'hFFFE);
    read("mulu_lo", 4'd3, 16'h0001);
    tick();
    check("sticky_lo", y, 16'h0001);
    issue(cmd(1'b1, 2'b00, 4'h9), 16'hFFFF, 16'h0002, '0);
    read("poll_busy", 4'd0, 16'h0001);
    wait_idle(n);
    check("muls_busy", W'(n), 16'd16);
    read("poll_idle", 4'd0, 16'h0000);
    read("muls_hi", 4'd2, 16'hFFFF);
    read("muls_lo", 4'd3, 16'hFFFE);
    issue(cmd(1'b0, 2'b00, 4'h9), 16'hFFFF, 16'h0002, '0);
    wait_idle(n);
    check("mulu2_busy", W'(n), 16'd17);
    read("mulu2_hi", 4'd2, 16'h0001);
    read("mulu2_lo", 4'd3, 16'hFFFE);
    issue(cmd(1'b0, 2'b00, 4'hA), 16'h0001, 16'h0000, 16'h0003);
    wait_idle(n);
    check("div_busy", W'(n), 16'd16);
    read("div_quot", 4'd4, 16'h5555);
    read("div_rem", 4'd5, 16'h0001);
    read("div_opt", 4'd1, OPT);
    read("div_keeps_hi", 4'd2, 16'h0001);
    issue(cmd(1'b0, 2'b00, 4'hA), 16'h0005, 16'h0000, 16'h0005);
    check("ovf_busy", W'(busy), '0);
    read("ovf_quot", 4'd4, 16'hFFFF);
    read("ovf_rem", 4'd5, 16'hFFFF);
    read("ovf_opt", 4'd1, OPT | 16'h0100);
    issue(cmd(1'b0, 2'b00, 4'hA), 16'h1234, 16'h5678, 16'h4321);
    wait_idle(n);
    check("div2_busy", W'(n), 16'd16);
    read("div2_quot", 4'd4, 16'h456C);
    read("div2_rem", 4'd5, 16'h1F8C);
    read("div2_opt", 4'd1, OPT);
    issue(cmd(1'b0, 2'b00, 4'hA), 16'h0001, 16'h0000, 16'h0003);
    repeat (3) tick();
    issue(cmd(1'b0, 2'b00, 4'h9), 16'h0002, 16'h0003, '0);
    wait_idle(n);
    check("clash_busy", W'(n), 16'd12);
    read("clash_quot", 4'd4, 16'h5555);
    read("clash_rem", 4'd5, 16'h0001);
    read("clash_hi", 4'd2, 16'h0001);
    read("clash_lo", 4'd3, 16'hFFFE);
`ifdef COPROC_MDU_SHIFT_EN
    issue(cmd(1'b0, 2'b10, 4'hB), 16'h8000, 16'h0000, 16'd4);
    wait_idle(n);
    check("sra_busy", W'(n), 16'd4);
    read("sra_hi", 4'd6, 16'hF800);
    read("sra_lo", 4'd7, 16'h0000);
    issue(cmd(1'b0, 2'b11, 4'hB), 16'h8000, 16'h0001, 16'd32);
    check("rol32_busy", W'(busy), '0);
    read("rol32_hi", 4'd6, 16'h8000);
    read("rol32_lo", 4'd7, 16'h0001);
    issue(cmd(1'b0, 2'b11, 4'hB), 16'h8000, 16'h0001, 16'd4);
    wait_idle(n);
    check("rol4_busy", W'(n), 16'd4);
    read("rol4_hi", 4'd6, 16'h0000);
    read("rol4_lo", 4'd7, 16'h0018);
    issue(cmd(1'b0, 2'b01, 4'hB), 16'h0001, 16'h0000, 16'd1);
    wait_idle(n);
    check("srl_busy", W'(n), 16'd1);
    read("srl_lo", 4'd7, 16'h8000);
    issue(cmd(1'b0, 2'b00, 4'hB), 16'h0000, 16'h0001, 16'd31);
    wait_idle(n);
    check("sll31_busy", W'(n), 16'd31);
    read("sll31_hi", 4'd6, 16'h8000);
    read("sll31_lo", 4'd7, 16'h0000);
    issue(cmd(1'b0, 2'b00, 4'hB), 16'h1234, 16'h5678, 16'd0);
    check("sll0_busy", W'(busy), '0);
    read("sll0_hi", 4'd6, 16'h1234);
    read("sll0_lo", 4'd7, 16'h5678);
`else
    issue(cmd(1'b0, 2'b00, 4'hB), 16'h1234, 16'h5678, 16'd4);
    check("noshf_busy", W'(busy), '0);
    read("noshf_hi", 4'd6, 16'h0000);
    read("noshf_lo", 4'd7, 16'h0000);
`endif
    issue(cmd(1'b0, 2'b00, 4'h9), 16'h1234, 16'h5678, '0);
    repeat (5) tick();
    check("pre_rst_busy", W'(busy), 16'h0001);
    #2 arstn = 1'b0;
    #1;
    check("arst_y", y, '0);
    check("arst_busy", W'(busy), '0);
    arstn = 1'b1;
    tick();
    read("arst_hi", 4'd2, '0);
    read("arst_lo", 4'd3, '0);
    read("arst_quot", 4'd4, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
